// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, requester IDs
// and the address range check.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (I/D) and processor_memory signal bundle; the arbiter uses the
// slave modport, the requester/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 16
);
    logic                 i_req;
    logic [ADDR_W-1:0]    i_addr;
    logic                 i_gnt;
    logic                 i_rvalid;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_err;

    logic                 d_req;
    logic                 d_we;
    logic [ADDR_W-1:0]    d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_err;

    logic [ADDR_W-1:0]    mem_address;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 mem_wren;
    logic [WORD_SIZE-1:0] mem_q;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_address, mem_data, mem_wren
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with combinational one-hot grant; bit 0 = I,
// bit 1 = D. On contention the requester not granted last time wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    req_id_e last_r;

    // grant selection
    always_comb begin
        gnt = 2'b00;
        if (!en) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = (last_r == REQ_D) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // last-grant history, starts at I so first contention goes to D
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r <= REQ_I;
        end else if (gnt != 2'b00) begin
            last_r <= gnt[REQ_D] ? REQ_D : REQ_I;
        end else begin
            last_r <= last_r;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares single-port processor_memory between fetch (I) and load/store (D):
// one transaction in flight, round-robin on contention, range errors answered.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          WORD_SIZE = 32,
    parameter int          ADDR_W    = 16,
    parameter int unsigned MEM_DEPTH = 4096
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus,
    output logic               busy
);
    state_e               state_r, state_nx_s;
    req_id_e              owner_r;
    logic [1:0]           arb_gnt_s;
    logic                 arb_en_s;
    logic                 i_in_range_s, d_in_range_s;
    logic [ADDR_W-1:0]    addr_hold_r;
    logic [WORD_SIZE-1:0] data_hold_r;
    logic                 i_rvalid_r, i_err_r, d_rvalid_r, d_err_r;
    logic [WORD_SIZE-1:0] i_rdata_r, d_rdata_r;

    assign i_in_range_s = in_range(32'(bus.i_addr), 32'(MEM_DEPTH));
    assign d_in_range_s = in_range(32'(bus.d_addr), 32'(MEM_DEPTH));
    assign arb_en_s     = (state_r == IDLE) && rst;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({bus.d_req, bus.i_req}),
        .en  (arb_en_s),
        .gnt (arb_gnt_s)
    );

    assign bus.i_gnt    = arb_gnt_s[REQ_I];
    assign bus.d_gnt    = arb_gnt_s[REQ_D];
    assign bus.i_rvalid = i_rvalid_r;
    assign bus.i_rdata  = i_rdata_r;
    assign bus.i_err    = i_err_r;
    assign bus.d_rvalid = d_rvalid_r;
    assign bus.d_rdata  = d_rdata_r;
    assign bus.d_err    = d_err_r;
    assign busy         = (state_r != IDLE);

    // next state and memory port drive; address/data hold when idle or out of range
    always_comb begin
        state_nx_s      = state_r;
        bus.mem_address = addr_hold_r;
        bus.mem_data    = data_hold_r;
        bus.mem_wren    = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_gnt_s[REQ_I] && i_in_range_s) begin
                    bus.mem_address = bus.i_addr;
                    state_nx_s      = RD_WAIT;
                end else if (arb_gnt_s[REQ_D] && d_in_range_s) begin
                    bus.mem_address = bus.d_addr;
                    bus.mem_data    = bus.d_wdata;
                    bus.mem_wren    = bus.d_we;
                    state_nx_s      = bus.d_we ? IDLE : RD_WAIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD_WAIT: state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // state, read owner and memory-port hold registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            owner_r     <= REQ_I;
            addr_hold_r <= {ADDR_W{1'b0}};
            data_hold_r <= {WORD_SIZE{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            addr_hold_r <= bus.mem_address;
            data_hold_r <= bus.mem_data;
            if (arb_gnt_s != 2'b00) begin
                owner_r <= arb_gnt_s[REQ_D] ? REQ_D : REQ_I;
            end else begin
                owner_r <= owner_r;
            end
        end
    end

    // response pulses: read data after RD_WAIT, immediate ack for stores/errors
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rvalid_r <= 1'b0;
            i_err_r    <= 1'b0;
            i_rdata_r  <= {WORD_SIZE{1'b0}};
            d_rvalid_r <= 1'b0;
            d_err_r    <= 1'b0;
            d_rdata_r  <= {WORD_SIZE{1'b0}};
        end else begin
            i_rvalid_r <= 1'b0;
            i_err_r    <= 1'b0;
            d_rvalid_r <= 1'b0;
            d_err_r    <= 1'b0;
            if (state_r == RD_WAIT) begin
                if (owner_r == REQ_I) begin
                    i_rvalid_r <= 1'b1;
                    i_rdata_r  <= bus.mem_q;
                end else begin
                    d_rvalid_r <= 1'b1;
                    d_rdata_r  <= bus.mem_q;
                end
            end else if (arb_gnt_s[REQ_I] && !i_in_range_s) begin
                i_rvalid_r <= 1'b1;
                i_err_r    <= 1'b1;
                i_rdata_r  <= {WORD_SIZE{1'b0}};
            end else if (arb_gnt_s[REQ_D] && (bus.d_we || !d_in_range_s)) begin
                d_rvalid_r <= 1'b1;
                d_err_r    <= !d_in_range_s;
                d_rdata_r  <= {WORD_SIZE{1'b0}};
            end else begin
                i_rdata_r <= i_rdata_r;
                d_rdata_r <= d_rdata_r;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural processor_memory
// (registered read, write on wren) attached to the memory side.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] mem [0:4095];

    mem_port_arbiter_if #(.WORD_SIZE(32), .ADDR_W(16)) bus ();

    mem_port_arbiter #(.WORD_SIZE(32), .ADDR_W(16), .MEM_DEPTH(4096)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_wren) mem[bus.mem_address[11:0]] <= bus.mem_data;
        bus.mem_q <= mem[bus.mem_address[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = 32'h0000_0000;
        mem[4]      = 32'hDEAD_BEEF;
        bus.mem_q   = 32'h0000_0000;
        bus.i_req   = 1'b1;
        bus.i_addr  = 16'h0004;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0010;
        bus.d_wdata = 32'hFFFF_FFFF;

        // reset: no grants or writes even with requests pending
        sample();
        check("rst_i_gnt", {31'd0, bus.i_gnt}, 32'd0);
        check("rst_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
        check("rst_wren", {31'd0, bus.mem_wren}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        next_cycle();
        rst = 1'b1;

        // fetch read of mem[4]
        next_cycle();
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0004;
        sample();
        check("rd_i_gnt", {31'd0, bus.i_gnt}, 32'd1);
        check("rd_addr", {16'd0, bus.mem_address}, 32'h0000_0004);
        check("rd_wren", {31'd0, bus.mem_wren}, 32'd0);
        next_cycle();
        bus.i_req = 1'b0;
        sample();
        check("rd_busy", {31'd0, busy}, 32'd1);
        check("rd_i_rvalid_n1", {31'd0, bus.i_rvalid}, 32'd0);
        next_cycle();
        sample();
        check("rd_i_rvalid_n2", {31'd0, bus.i_rvalid}, 32'd1);
        check("rd_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        check("rd_i_err", {31'd0, bus.i_err}, 32'd0);
        check("rd_busy_done", {31'd0, busy}, 32'd0);

        // store 0x12345678 to 0x10, then load it back
        next_cycle();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0010;
        bus.d_wdata = 32'h1234_5678;
        sample();
        check("st_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
        check("st_wren", {31'd0, bus.mem_wren}, 32'd1);
        check("st_addr", {16'd0, bus.mem_address}, 32'h0000_0010);
        check("st_data", bus.mem_data, 32'h1234_5678);
        next_cycle();
        bus.d_we = 1'b0;
        sample();
        check("st_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
        check("st_d_rdata", bus.d_rdata, 32'd0);
        check("st_d_err", {31'd0, bus.d_err}, 32'd0);
        check("ld_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
        check("ld_wren", {31'd0, bus.mem_wren}, 32'd0);
        next_cycle();
        bus.d_req = 1'b0;
        sample();
        check("ld_d_rvalid_n1", {31'd0, bus.d_rvalid}, 32'd0);
        check("ld_wren_once", {31'd0, bus.mem_wren}, 32'd0);
        next_cycle();
        sample();
        check("ld_d_rvalid_n2", {31'd0, bus.d_rvalid}, 32'd1);
        check("ld_d_rdata", bus.d_rdata, 32'h1234_5678);

        // out-of-range load at MEM_DEPTH
        next_cycle();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h1000;
        sample();
        check("oor_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
        check("oor_wren", {31'd0, bus.mem_wren}, 32'd0);
        next_cycle();
        bus.d_req = 1'b0;
        sample();
        check("oor_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
        check("oor_d_err", {31'd0, bus.d_err}, 32'd1);
        check("oor_d_rdata", bus.d_rdata, 32'd0);
        check("oor_busy", {31'd0, busy}, 32'd0);

        // reset while a fetch read is in RD_WAIT
        next_cycle();
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0004;
        sample();
        check("mr_i_gnt", {31'd0, bus.i_gnt}, 32'd1);
        next_cycle();
        bus.i_req = 1'b0;
        sample();
        check("mr_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_i_rdata", bus.i_rdata, 32'd0);
        next_cycle();
        sample();
        check("mr_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);
        next_cycle();
        rst = 1'b1;

        // contention after reset: D, I, D with rvalid coinciding with next grant
        next_cycle();
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0004;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0010;
        sample();
        check("ct0_gnt", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd2);
        next_cycle();
        sample();
        check("ct1_gnt", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd0);
        check("ct1_addr_hold", {16'd0, bus.mem_address}, 32'h0000_0010);
        next_cycle();
        sample();
        check("ct2_gnt", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd1);
        check("ct2_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
        check("ct2_d_rdata", bus.d_rdata, 32'h1234_5678);
        check("ct2_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);
        next_cycle();
        sample();
        check("ct3_gnt", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd0);
        next_cycle();
        sample();
        check("ct4_gnt", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd2);
        check("ct4_i_rvalid", {31'd0, bus.i_rvalid}, 32'd1);
        check("ct4_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        check("ct4_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
        next_cycle();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        sample();
        check("ct5_gnt", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd0);
        next_cycle();
        sample();
        check("ct6_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
        check("ct6_d_rdata", bus.d_rdata, 32'h1234_5678);
        check("ct6_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
